// File: rtl/normalize_shift_ctrl.sv
// Post-add normalisation controller: locates the leading one of the sum word
// by a chunked MSB-first scan and drives the downstream mantissa shifter.
module normalize_shift_ctrl #(
   parameter int SCAN_W = 4,
   parameter int EXP_W  = 8
) (
   input  logic             clk,
   input  logic             res,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [27:0]      sum_in,
   input  logic [EXP_W-1:0] exp_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [27:0]      mant_out,
   output logic             shift_right_en,
   output logic [7:0]       shift_right_bits,
   output logic             shift_left_en,
   output logic [7:0]       shift_left_bits,
   output logic [EXP_W-1:0] exp_out,
   output logic             zero,
   output logic             overflow,
   output logic             underflow
);

   localparam int MAG_W  = 26;
   localparam int NCHUNK = (MAG_W + SCAN_W - 1) / SCAN_W;
   localparam int PAD_W  = NCHUNK * SCAN_W;
   localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam int CW     = (EXP_W > 8) ? EXP_W : 8;

   localparam logic [EXP_W-1:0] EXP_ONE = EXP_W'(1);
   localparam logic [EXP_W-1:0] EXP_SAT = '1;
   localparam logic [EXP_W-1:0] EXP_OVF = EXP_SAT - EXP_ONE;
   localparam logic [KW-1:0]    K_LAST  = KW'(NCHUNK - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SCAN,
      ST_DONE
   } state_t;

   state_t state_q, state_d;

   logic [27:0]      sum_q;
   logic [EXP_W-1:0] exp_q;
   logic [KW-1:0]    k_q;

   logic [PAD_W-1:0]  mag_pad;
   logic [PAD_W-1:0]  shifted;
   logic [SCAN_W-1:0] chunk;
   logic [7:0]        pos;
   logic              found;
   logic [7:0]        lz;
   logic [CW-1:0]     lz_e;
   logic [CW-1:0]     exp_e;
   logic              is_carry;
   logic              is_zero;
   logic              finish;

   logic             n_re;
   logic [7:0]       n_rb;
   logic             n_le;
   logic [7:0]       n_lb;
   logic [EXP_W-1:0] n_eo;
   logic             n_z;
   logic             n_ov;
   logic             n_uf;

   // State register
   always_ff @(posedge clk or negedge res) begin
      if (!res) state_q <= ST_IDLE;
      else      state_q <= state_d;
   end

   // Carry and zero words still pass through one SCAN cycle so that their
   // results appear one edge after capture, like a chunk-0 hit.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (in_valid)  state_d = ST_SCAN;
         ST_SCAN: if (finish)    state_d = ST_DONE;
         ST_DONE: if (out_ready) state_d = ST_IDLE;
         default:                state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state_q == ST_IDLE);
      out_valid = (state_q == ST_DONE);
   end

   // Chunk k examined MSB first; the magnitude is zero-padded below bit 0.
   always_comb begin
      mag_pad = PAD_W'(sum_q[25:0]) << (PAD_W - MAG_W);
      shifted = mag_pad << (k_q * SCAN_W);
      chunk   = shifted[PAD_W-1 -: SCAN_W];
      pos     = '0;
      found   = 1'b0;
      for (int unsigned i = 0; i < SCAN_W; i++) begin
         if (!found && chunk[SCAN_W-1-i]) begin
            found = 1'b1;
            pos   = 8'(i);
         end
      end
      lz       = 8'(k_q * SCAN_W) + pos;
      lz_e     = CW'(lz);
      exp_e    = CW'(exp_q);
      is_carry = sum_q[26];
      is_zero  = (sum_q[26:0] == '0);
      finish   = is_carry || is_zero || found || (k_q == K_LAST);
   end

   always_comb begin
      n_re = 1'b0;
      n_rb = '0;
      n_le = 1'b0;
      n_lb = '0;
      n_eo = '0;
      n_z  = 1'b0;
      n_ov = 1'b0;
      n_uf = 1'b0;
      if (is_carry) begin
         n_re = 1'b1;
         n_rb = 8'd1;
         if (exp_q >= EXP_OVF) begin
            n_ov = 1'b1;
            n_eo = EXP_SAT;
         end else begin
            n_eo = exp_q + EXP_ONE;
         end
      end else if (is_zero) begin
         n_z = 1'b1;
      end else if (lz == 8'd0) begin
         n_eo = exp_q;
      end else if (lz_e < exp_e) begin
         n_le = 1'b1;
         n_lb = lz;
         n_eo = exp_q - EXP_W'(lz);
      end else begin
         n_uf = 1'b1;
         n_lb = (exp_q == '0) ? 8'd0 : 8'(exp_q - EXP_ONE);
         n_le = (n_lb != 8'd0);
      end
   end

   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         sum_q            <= '0;
         exp_q            <= '0;
         k_q              <= '0;
         shift_right_en   <= 1'b0;
         shift_right_bits <= '0;
         shift_left_en    <= 1'b0;
         shift_left_bits  <= '0;
         exp_out          <= '0;
         zero             <= 1'b0;
         overflow         <= 1'b0;
         underflow        <= 1'b0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (in_valid) begin
                  sum_q <= sum_in;
                  exp_q <= exp_in;
                  k_q   <= '0;
               end
            end
            ST_SCAN: begin
               if (finish) begin
                  shift_right_en   <= n_re;
                  shift_right_bits <= n_rb;
                  shift_left_en    <= n_le;
                  shift_left_bits  <= n_lb;
                  exp_out          <= n_eo;
                  zero             <= n_z;
                  overflow         <= n_ov;
                  underflow        <= n_uf;
               end else begin
                  k_q <= k_q + KW'(1);
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  shift_right_en   <= 1'b0;
                  shift_right_bits <= '0;
                  shift_left_en    <= 1'b0;
                  shift_left_bits  <= '0;
                  exp_out          <= '0;
                  zero             <= 1'b0;
                  overflow         <= 1'b0;
                  underflow        <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign mant_out = sum_q;

endmodule

// File: tb/tb_normalize_shift_ctrl.sv
// Self-checking bench for normalize_shift_ctrl: directed cases, reset mid-scan,
// then randomized words compared against a bit-index reference model.
module tb_normalize_shift_ctrl;

   logic        clk = 1'b0;
   logic        res;
   logic        in_valid;
   logic        in_ready;
   logic [27:0] sum_in;
   logic [7:0]  exp_in;
   logic        out_valid;
   logic        out_ready;
   logic [27:0] mant_out;
   logic        shift_right_en;
   logic [7:0]  shift_right_bits;
   logic        shift_left_en;
   logic [7:0]  shift_left_bits;
   logic [7:0]  exp_out;
   logic        zero;
   logic        overflow;
   logic        underflow;

   int checks = 0;
   int errors = 0;

   typedef struct {
      bit       re;
      bit [7:0] rb;
      bit       le;
      bit [7:0] lb;
      bit [7:0] eo;
      bit       z;
      bit       o;
      bit       u;
      int       lat;
   } exp_t;

   normalize_shift_ctrl #(.SCAN_W(4), .EXP_W(8)) dut (
      .clk              (clk),
      .res              (res),
      .in_valid         (in_valid),
      .in_ready         (in_ready),
      .sum_in           (sum_in),
      .exp_in           (exp_in),
      .out_valid        (out_valid),
      .out_ready        (out_ready),
      .mant_out         (mant_out),
      .shift_right_en   (shift_right_en),
      .shift_right_bits (shift_right_bits),
      .shift_left_en    (shift_left_en),
      .shift_left_bits  (shift_left_bits),
      .exp_out          (exp_out),
      .zero             (zero),
      .overflow         (overflow),
      .underflow        (underflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Leading one found by bit index; latency is one edge per 4-bit chunk scanned.
   function automatic exp_t model(input logic [27:0] s, input logic [7:0] e);
      exp_t r;
      int   top;
      int   lz;
      r.re = 0; r.rb = 0; r.le = 0; r.lb = 0; r.eo = 0;
      r.z = 0; r.o = 0; r.u = 0; r.lat = 1;
      if (s[26]) begin
         r.re = 1;
         r.rb = 1;
         if (int'(e) >= 254) begin
            r.o  = 1;
            r.eo = 8'hFF;
         end else begin
            r.eo = 8'(int'(e) + 1);
         end
      end else if (s[26:0] == 27'd0) begin
         r.z = 1;
      end else begin
         top = 0;
         for (int i = 0; i <= 25; i++) if (s[i]) top = i;
         lz    = 25 - top;
         r.lat = lz / 4 + 1;
         if (lz == 0) begin
            r.eo = e;
         end else if (lz < int'(e)) begin
            r.le = 1;
            r.lb = 8'(lz);
            r.eo = 8'(int'(e) - lz);
         end else begin
            r.u  = 1;
            r.lb = (e == 0) ? 8'd0 : 8'(int'(e) - 1);
            r.le = (r.lb != 0);
         end
      end
      return r;
   endfunction

   task automatic check_fields(input exp_t m, input logic [27:0] s);
      check("out_valid", out_valid, 1);
      check("in_ready_done", in_ready, 0);
      check("mant_out", mant_out, s);
      check("right_en", shift_right_en, m.re);
      check("right_bits", shift_right_bits, m.rb);
      check("left_en", shift_left_en, m.le);
      check("left_bits", shift_left_bits, m.lb);
      check("exp_out", exp_out, m.eo);
      check("zero", zero, m.z);
      check("overflow", overflow, m.o);
      check("underflow", underflow, m.u);
   endtask

   task automatic run_txn(input logic [27:0] s, input logic [7:0] e, input int hold);
      exp_t m;
      int   lat;
      bit   got;
      m = model(s, e);
      @(negedge clk);
      check("in_ready_idle", in_ready, 1);
      in_valid = 1'b1;
      sum_in   = s;
      exp_in   = e;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      sum_in   = 28'($urandom);
      exp_in   = 8'($urandom);
      check("in_ready_busy", in_ready, 0);
      check("valid_early", out_valid, 0);
      got = 0;
      lat = 0;
      for (int c = 1; c <= 40 && !got; c++) begin
         @(posedge clk);
         #1;
         if (out_valid === 1'b1) begin
            got = 1;
            lat = c;
         end
      end
      check("latency", lat, m.lat);
      if (got) begin
         check_fields(m, s);
         for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            check_fields(m, s);
         end
         out_ready = 1'b1;
         @(posedge clk);
         #1;
         out_ready = 1'b0;
         check("valid_clear", out_valid, 0);
         check("in_ready_back", in_ready, 1);
         check("flags_clear", {zero, overflow, underflow, shift_left_en, shift_right_en}, 0);
      end
   endtask

   initial begin
      logic [27:0] r;
      logic [27:0] mask;
      logic [27:0] s;
      logic [7:0]  e;
      int          p;

      res       = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      sum_in    = '0;
      exp_in    = '0;
      #1;
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_outputs", {mant_out, shift_right_en, shift_right_bits, shift_left_en,
                            shift_left_bits, exp_out, zero, overflow, underflow} == '0, 1);
      repeat (2) @(negedge clk);
      res = 1'b1;

      run_txn(28'h4000000, 8'h80, 0);
      run_txn(28'h2000000, 8'h7F, 0);
      run_txn(28'h0100000, 8'h80, 0);
      run_txn(28'h8000000, 8'h90, 0);
      run_txn(28'h0000008, 8'h05, 0);
      run_txn(28'h4000000, 8'hFE, 5);
      run_txn(28'h4000000, 8'hFD, 0);
      run_txn(28'h0000001, 8'h00, 0);
      run_txn(28'h0000001, 8'h01, 0);
      run_txn(28'h1000000, 8'h02, 1);
      run_txn(28'h0000002, 8'h30, 0);

      // Reset while the scan is in progress
      @(negedge clk);
      in_valid = 1'b1;
      sum_in   = 28'h0000008;
      exp_in   = 8'h05;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      res = 1'b0;
      #1;
      check("midscan_in_ready", in_ready, 1);
      check("midscan_out_valid", out_valid, 0);
      check("midscan_outputs", {mant_out, shift_right_en, shift_right_bits, shift_left_en,
                                shift_left_bits, exp_out, zero, overflow, underflow} == '0, 1);
      @(negedge clk);
      res = 1'b1;
      run_txn(28'h0100000, 8'h80, 0);

      for (int t = 0; t < 200; t++) begin
         if ($urandom_range(0, 9) == 0) begin
            s = {1'($urandom), 27'd0};
         end else begin
            p    = $urandom_range(0, 26);
            r    = 28'($urandom);
            mask = (28'd1 << p) - 28'd1;
            s    = (r & mask) | (28'd1 << p) | {1'($urandom), 27'd0};
         end
         case ($urandom_range(0, 3))
            0:       e = 8'($urandom_range(0, 30));
            1:       e = 8'($urandom_range(250, 255));
            default: e = 8'($urandom);
         endcase
         run_txn(s, e, $urandom_range(0, 2));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
